// File: rtl/plab5_mcore_dma_arb_pkg.sv
// plab5_mcore_dma_arb_pkg: arbiter FSM state encodings and response error causes
package plab5_mcore_dma_arb_pkg;
  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_check = 3'd1,
    st_req   = 3'd2,
    st_wait  = 3'd3,
    st_resp  = 3'd4
  } state_t;
  typedef enum logic [1:0] {
    cause_none    = 2'd0,
    cause_deny    = 2'd1,
    cause_abort   = 2'd2,
    cause_timeout = 2'd3
  } cause_t;
endpackage

// File: rtl/plab5_mcore_rr_picker.sv
// plab5_mcore_rr_picker: first valid requester at or after ptr, searching upward with wrap
module plab5_mcore_rr_picker #(
  parameter int p_nreqs = 2
) (
  input  logic [p_nreqs-1:0]         val,
  input  logic [$clog2(p_nreqs)-1:0] ptr,
  output logic [p_nreqs-1:0]         win,
  output logic [$clog2(p_nreqs)-1:0] idx
);
  localparam int iw = $clog2(p_nreqs);
  logic [iw-1:0] j;
  always_comb begin
    win = '0;
    idx = '0;
    j = '0;
    for (int i = p_nreqs - 1; i >= 0; i--) begin
      j = iw'((int'(ptr) + i) % p_nreqs);
      if (val[j]) begin
        idx = j;
        win = p_nreqs'(1) << j;
      end
    end
  end
endmodule

// File: rtl/plab5_mcore_dma_domain_arbiter.sv
// plab5_mcore_dma_domain_arbiter: round-robin, domain-checked sharing of the DMA debug command port
module plab5_mcore_dma_domain_arbiter
  import plab5_mcore_dma_arb_pkg::*;
#(
  parameter int p_nreqs      = 2,
  parameter int p_addr_nbits = 32,
  parameter int p_data_nbits = 32,
  parameter int p_timeout    = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nreqs-1:0]                req_val,
  input  logic [p_nreqs-1:0]                req_domain,
  input  logic [p_nreqs*p_addr_nbits-1:0]   req_src_addr,
  input  logic [p_nreqs*p_addr_nbits-1:0]   req_dest_addr,
  input  logic [p_nreqs-1:0]                req_inst,
  output logic [p_nreqs-1:0]                req_ack,
  output logic                              req_err,
  output logic [p_data_nbits-1:0]           req_data,
  output logic                              req_resp_domain,
  output logic [$clog2(p_nreqs)-1:0]        grant_id,
  input  logic                              dma_domain,
  output logic                              dma_db_val,
  output logic [p_addr_nbits-1:0]           dma_db_src_addr,
  output logic [p_addr_nbits-1:0]           dma_db_dest_addr,
  output logic                              dma_db_inst,
  input  logic                              dma_ack,
  input  logic [p_data_nbits-1:0]           dma_db_debug_data
);
  localparam int iw = $clog2(p_nreqs);
  localparam int cw = $clog2(p_timeout + 1);
  state_t                  state, state_n;
  cause_t                  cause, cause_n;
  logic [iw-1:0]           ptr, idx, win_idx;
  logic [p_nreqs-1:0]      win;
  logic                    dom, inst, dom_dma;
  logic [p_addr_nbits-1:0] src, dest, win_src, win_dest;
  logic [p_data_nbits-1:0] data;
  logic [cw-1:0]           cnt;
  logic                    same, hit, go, resp;
  assign same = dma_domain == dom_dma;
  assign hit  = cnt >= cw'(p_timeout - 1);
  assign go   = state == st_req && same;
  assign resp = state == st_resp;
  plab5_mcore_rr_picker #(.p_nreqs(p_nreqs)) u_pick (
    .val (req_val),
    .ptr (ptr),
    .win (win),
    .idx (win_idx)
  );
  always_comb begin
    win_src  = '0;
    win_dest = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      win_src  |= win[i] ? req_src_addr[i*p_addr_nbits +: p_addr_nbits] : '0;
      win_dest |= win[i] ? req_dest_addr[i*p_addr_nbits +: p_addr_nbits] : '0;
    end
  end
  always_comb begin
    state_n = state;
    cause_n = cause;
    case (state)
      st_idle: if (|win) begin
        state_n = st_check;
        cause_n = cause_none;
      end
      st_check: begin
        state_n = dom >= dma_domain ? st_req : st_resp;
        cause_n = dom >= dma_domain ? cause_none : cause_deny;
      end
      st_req: begin
        state_n = same ? st_wait : st_resp;
        cause_n = same ? cause_none : cause_abort;
      end
      st_wait: if (dma_ack && same) begin
        state_n = st_resp;
        cause_n = cause_none;
      end else if (!same) begin
        state_n = st_resp;
        cause_n = cause_abort;
      end else if (hit) begin
        state_n = st_resp;
        cause_n = cause_timeout;
      end
      st_resp: state_n = st_idle;
      default: state_n = st_idle;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= st_idle;
      cause   <= cause_none;
      ptr     <= '0;
      idx     <= '0;
      dom     <= 1'b0;
      inst    <= 1'b0;
      dom_dma <= 1'b0;
      src     <= '0;
      dest    <= '0;
      data    <= '0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      if (state == st_idle && |win) begin
        idx  <= win_idx;
        dom  <= |(req_domain & win);
        inst <= |(req_inst & win);
        src  <= win_src;
        dest <= win_dest;
        data <= '0;
      end
      if (state == st_check) dom_dma <= dma_domain;
      cnt <= state != st_wait ? '0 : cnt == cw'(p_timeout) ? cnt : cnt + 1'b1;
      if (state == st_wait && dma_ack && same) data <= dma_db_debug_data;
      if (resp) ptr <= idx == iw'(p_nreqs - 1) ? '0 : idx + 1'b1;
    end
  end
  assign req_ack          = resp ? p_nreqs'(1) << idx : '0;
  assign req_err          = resp && cause != cause_none;
  assign req_data         = resp && cause == cause_none ? data : '0;
  assign req_resp_domain  = dom;
  assign grant_id         = idx;
  assign dma_db_val       = go;
  assign dma_db_src_addr  = go ? src : '0;
  assign dma_db_dest_addr = go ? dest : '0;
  assign dma_db_inst      = go && inst;
endmodule

// File: tb/tb_plab5_mcore_dma_domain_arbiter.sv
// tb_plab5_mcore_dma_domain_arbiter: directed vector table plus reset, late-ack and round-robin sequences
module tb_plab5_mcore_dma_domain_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_val, req_domain, req_inst;
  logic [63:0] req_src_addr, req_dest_addr;
  logic [1:0]  req_ack;
  logic        req_err;
  logic [31:0] req_data;
  logic        req_resp_domain;
  logic        grant_id;
  logic        dma_domain;
  logic        dma_db_val;
  logic [31:0] dma_db_src_addr, dma_db_dest_addr;
  logic        dma_db_inst;
  logic        dma_ack;
  logic [31:0] dma_db_debug_data;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  plab5_mcore_dma_domain_arbiter #(
    .p_nreqs(2), .p_addr_nbits(32), .p_data_nbits(32), .p_timeout(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_val           (req_val),
    .req_domain        (req_domain),
    .req_src_addr      (req_src_addr),
    .req_dest_addr     (req_dest_addr),
    .req_inst          (req_inst),
    .req_ack           (req_ack),
    .req_err           (req_err),
    .req_data          (req_data),
    .req_resp_domain   (req_resp_domain),
    .grant_id          (grant_id),
    .dma_domain        (dma_domain),
    .dma_db_val        (dma_db_val),
    .dma_db_src_addr   (dma_db_src_addr),
    .dma_db_dest_addr  (dma_db_dest_addr),
    .dma_db_inst       (dma_db_inst),
    .dma_ack           (dma_ack),
    .dma_db_debug_data (dma_db_debug_data)
  );
  typedef struct {
    logic [1:0]  val, dom, inst;
    logic [63:0] src, dest;
    logic        dma_dom;
    int          flip_at, ack_at;
    logic [31:0] data;
    logic [1:0]  e_ack;
    logic        e_err;
    logic [31:0] e_data;
    int          e_ack_at, e_val_at;
    logic [31:0] e_src, e_dest;
    logic        e_inst, e_grant, e_rdom;
  } vec_t;
  vec_t vs[11];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string tag);
    int ack_at, val_at;
    logic leak, err_v, g_v, rd_v, i_v;
    logic [1:0] ack_v;
    logic [31:0] data_v, s_v, de_v;
    ack_at = -1; val_at = -1; leak = 0; err_v = 0; g_v = 0; rd_v = 0; i_v = 0;
    ack_v = 0; data_v = 0; s_v = 0; de_v = 0;
    @(posedge clk); #1;
    req_val = v.val; req_domain = v.dom; req_inst = v.inst;
    req_src_addr = v.src; req_dest_addr = v.dest; dma_domain = v.dma_dom;
    for (int c = 0; c < 30 && ack_at < 0; c++) begin
      if (c == v.flip_at) dma_domain = ~v.dma_dom;
      dma_ack = (c == v.ack_at);
      dma_db_debug_data = (c == v.ack_at) ? v.data : (32'hDEAD0000 | 32'(c));
      @(negedge clk);
      if (dma_db_val && val_at < 0) begin
        val_at = c; s_v = dma_db_src_addr; de_v = dma_db_dest_addr; i_v = dma_db_inst;
      end
      if (!dma_db_val && (dma_db_src_addr != 0 || dma_db_dest_addr != 0 || dma_db_inst)) leak = 1;
      if (req_ack != 0) begin
        ack_at = c; ack_v = req_ack; err_v = req_err; data_v = req_data;
        g_v = grant_id; rd_v = req_resp_domain;
      end else if (req_data != 0 || req_err) leak = 1;
      @(posedge clk); #1;
    end
    req_val = 0; dma_ack = 0; dma_domain = v.dma_dom;
    chk({tag, ".ack_cycle"}, 64'(ack_at), 64'(v.e_ack_at));
    chk({tag, ".dma_val_cycle"}, 64'(val_at), 64'(v.e_val_at));
    chk({tag, ".req_ack"}, 64'(ack_v), 64'(v.e_ack));
    chk({tag, ".req_err"}, 64'(err_v), 64'(v.e_err));
    chk({tag, ".req_data"}, 64'(data_v), 64'(v.e_data));
    chk({tag, ".grant_id"}, 64'(g_v), 64'(v.e_grant));
    chk({tag, ".resp_domain"}, 64'(rd_v), 64'(v.e_rdom));
    chk({tag, ".idle_leak"}, 64'(leak), 64'(0));
    if (val_at >= 0 && v.e_val_at >= 0) begin
      chk({tag, ".dma_src"}, 64'(s_v), 64'(v.e_src));
      chk({tag, ".dma_dest"}, 64'(de_v), 64'(v.e_dest));
      chk({tag, ".dma_inst"}, 64'(i_v), 64'(v.e_inst));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic flag;
    logic [1:0] drop;
    logic nack;
    int gs[4], at[4], k;
    vec_t vr;
    reset = 0; req_val = 0; req_domain = 0; req_inst = 0; req_src_addr = 0; req_dest_addr = 0;
    dma_domain = 0; dma_ack = 0; dma_db_debug_data = 0;
    vs[0]  = '{2'b01, 2'b01, 2'b01, {32'h900, 32'h100}, {32'hA00, 32'h200}, 1'b1, -1, 4, 32'hCAFE,
               2'b01, 1'b0, 32'hCAFE, 5, 2, 32'h100, 32'h200, 1'b1, 1'b0, 1'b1};
    vs[1]  = '{2'b10, 2'b00, 2'b10, {32'h111, 32'h110}, {32'h211, 32'h210}, 1'b1, -1, -1, 32'h0,
               2'b10, 1'b1, 32'h0, 2, -1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
    vs[2]  = '{2'b01, 2'b01, 2'b00, {32'h121, 32'h120}, {32'h221, 32'h220}, 1'b1, -1, -1, 32'h0,
               2'b01, 1'b1, 32'h0, 7, 2, 32'h120, 32'h220, 1'b0, 1'b0, 1'b1};
    vs[3]  = '{2'b10, 2'b10, 2'b10, {32'h131, 32'h130}, {32'h231, 32'h230}, 1'b1, -1, 3, 32'h1234,
               2'b10, 1'b0, 32'h1234, 4, 2, 32'h131, 32'h231, 1'b1, 1'b1, 1'b1};
    vs[4]  = '{2'b01, 2'b00, 2'b01, {32'h141, 32'h140}, {32'h241, 32'h240}, 1'b0, -1, 6, 32'hBEEF,
               2'b01, 1'b0, 32'hBEEF, 7, 2, 32'h140, 32'h240, 1'b1, 1'b0, 1'b0};
    vs[5]  = '{2'b10, 2'b10, 2'b00, {32'h151, 32'h150}, {32'h251, 32'h250}, 1'b0, -1, 3, 32'h55,
               2'b10, 1'b0, 32'h55, 4, 2, 32'h151, 32'h251, 1'b0, 1'b1, 1'b1};
    vs[6]  = '{2'b11, 2'b11, 2'b10, {32'h161, 32'h160}, {32'h261, 32'h260}, 1'b1, -1, 3, 32'h6666,
               2'b01, 1'b0, 32'h6666, 4, 2, 32'h160, 32'h260, 1'b0, 1'b0, 1'b1};
    vs[7]  = '{2'b11, 2'b11, 2'b10, {32'h171, 32'h170}, {32'h271, 32'h270}, 1'b1, -1, 3, 32'h7777,
               2'b10, 1'b0, 32'h7777, 4, 2, 32'h171, 32'h271, 1'b1, 1'b1, 1'b1};
    vs[8]  = '{2'b01, 2'b01, 2'b01, {32'h181, 32'h180}, {32'h281, 32'h280}, 1'b1, 4, 5, 32'hF00D,
               2'b01, 1'b1, 32'h0, 5, 2, 32'h180, 32'h280, 1'b1, 1'b0, 1'b1};
    vs[9]  = '{2'b10, 2'b10, 2'b10, {32'h191, 32'h190}, {32'h291, 32'h290}, 1'b1, 2, -1, 32'h0,
               2'b10, 1'b1, 32'h0, 3, -1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vs[10] = '{2'b01, 2'b00, 2'b01, {32'h0F1, 32'h0F0}, {32'h2F1, 32'h2F0}, 1'b1, -1, 1, 32'h9999,
               2'b01, 1'b1, 32'h0, 2, -1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vr     = '{2'b11, 2'b01, 2'b01, {32'h1B1, 32'h1B0}, {32'h2B1, 32'h2B0}, 1'b1, -1, 3, 32'h7070,
               2'b01, 1'b0, 32'h7070, 4, 2, 32'h1B0, 32'h2B0, 1'b1, 1'b0, 1'b1};
    #2;
    chk("reset.outs", 64'({req_ack, req_err, req_data, req_resp_domain, grant_id, dma_db_val, dma_db_inst}), 64'(0));
    chk("reset.dma_addr", {dma_db_src_addr, dma_db_dest_addr}, 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1;
    foreach (vs[i]) run(vs[i], $sformatf("v%0d", i));
    flag = 0;
    dma_ack = 1; dma_db_debug_data = 32'hBAD0;
    repeat (3) begin
      @(negedge clk);
      if (req_ack != 0 || req_data != 0 || dma_db_val) flag = 1;
      @(posedge clk); #1;
    end
    dma_ack = 0;
    chk("idle.ack_ignored", 64'(flag), 64'(0));
    @(posedge clk); #1;
    req_val = 2'b10; req_domain = 2'b10; req_inst = 2'b10;
    req_src_addr = {32'h1A1, 32'h1A0}; req_dest_addr = {32'h2A1, 32'h2A0}; dma_domain = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst.pre_grant", 64'(grant_id), 64'(1));
    #1 reset = 0;
    #1;
    chk("rst.outs", 64'({req_ack, req_err, req_data, req_resp_domain, grant_id, dma_db_val, dma_db_inst}), 64'(0));
    chk("rst.dma_addr", {dma_db_src_addr, dma_db_dest_addr}, 64'(0));
    @(posedge clk); #1;
    reset = 1; req_val = 0; dma_ack = 1; dma_db_debug_data = 32'h5A5A;
    flag = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ack != 0 || dma_db_val || req_data != 0) flag = 1;
      @(posedge clk); #1;
      dma_ack = 0;
    end
    chk("rst.no_ack_after", 64'(flag), 64'(0));
    run(vr, "rst.ptr0");
    drop = 0; nack = 0; k = 0;
    req_domain = 2'b11; req_inst = 2'b01; dma_domain = 1;
    req_src_addr = {32'h3C1, 32'h3C0}; req_dest_addr = {32'h4C1, 32'h4C0};
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(posedge clk); #1;
      req_val = 2'b11 & ~drop; dma_ack = nack; dma_db_debug_data = 32'hA0000000 | 32'(c);
      drop = 0;
      @(negedge clk);
      nack = dma_db_val;
      if (req_ack != 0) begin
        gs[k] = int'(grant_id); at[k] = c;
        chk("rr.err", 64'(req_err), 64'(0));
        chk("rr.data", 64'(req_data), 64'(32'hA0000000 | 32'(c - 1)));
        drop = req_ack;
        k++;
      end
    end
    @(posedge clk); #1;
    req_val = 0; dma_ack = 0;
    chk("rr.count", 64'(k), 64'(4));
    for (int i = 0; i < k; i++) chk($sformatf("rr.grant%0d", i), 64'(gs[i]), 64'(i % 2 == 0 ? 1 : 0));
    for (int i = 1; i < k; i++) chk($sformatf("rr.spacing%0d", i), 64'(at[i] - at[i-1]), 64'(5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
